// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the register-file write-back
//               arbiter and its pending-write scoreboard.
//               DATA_W   - write data width
//               ADDR_W   - register address width
//               NUM_REGS - number of architectural registers (2**ADDR_W)
//               CNT_W    - width of each per-register pending counter
//               requester_e - identifies the write-back producer holding
//                             round-robin priority
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = 2;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } requester_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_pending_cnt.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pending_cnt
// Description : Saturating up/down pending-write counter for one register.
//               Simultaneous increment and decrement leave the count alone;
//               an increment at the maximum value and a decrement at zero are
//               both ignored.
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset (count -> 0)
//               i_inc   - a destination reservation for this register
//               i_dec   - the register file commits this register
//               o_busy  - count is nonzero
//               o_sat   - count is at its maximum value
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_pending_cnt #(
    parameter int CNT_W = regfile_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_busy,
    output logic o_sat
);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;
    logic             w_nonzero;

    assign w_sat     = &r_count;
    assign w_nonzero = |r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end else if (i_dec && !i_inc && w_nonzero) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_busy = w_nonzero;
    assign o_sat  = w_sat;

endmodule : regfile_pending_cnt
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register file's single write port between the ALU
//               and memory-load write-back paths (valid/ready, round-robin)
//               and tracks per-register pending writes for hazard detection.
// Ports       : clk, rst_n             - clock, async active-low reset
//               reserve_valid/_reg     - issue stage claims a destination
//               alu_valid/_reg/_data   - ALU write-back request
//               alu_ready              - ALU request accepted this cycle
//               mem_valid/_reg/_data   - load write-back request
//               mem_ready              - load request accepted this cycle
//               rf_write               - registered RegWrite to register file
//               rf_write_register      - registered write address
//               rf_write_data          - registered write data
//               busy                   - per-register pending-write flags
//               reserve_overflow       - pulse: a reserve hit a saturated count
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reserve_valid,
    input  logic [ADDR_W-1:0]   reserve_reg,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                rf_write,
    output logic [ADDR_W-1:0]   rf_write_register,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic [NUM_REGS-1:0] busy,
    output logic                reserve_overflow
);

    requester_e          r_prio;
    logic                r_rf_write;
    logic [ADDR_W-1:0]   r_rf_write_register;
    logic [DATA_W-1:0]   r_rf_write_data;
    logic                r_reserve_overflow;

    logic                w_grant;
    logic [ADDR_W-1:0]   w_sel_reg;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REGS-1:0] w_drop;

    // ------------------------------------------------------------------
    // Arbiter: a lone request always wins; under contention the holder
    // of prio wins. Ready is purely combinational from the valids.
    // ------------------------------------------------------------------
    assign alu_ready  = alu_valid & (~mem_valid | (r_prio == REQ_ALU));
    assign mem_ready  = mem_valid & (~alu_valid | (r_prio == REQ_MEM));
    assign w_grant    = alu_ready | mem_ready;
    assign w_sel_reg  = alu_ready ? alu_reg  : mem_reg;
    assign w_sel_data = alu_ready ? alu_data : mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio              <= REQ_ALU;
            r_rf_write          <= 1'b0;
            r_rf_write_register <= '0;
            r_rf_write_data     <= '0;
        end else if (w_grant) begin
            // Register 0 is hard-wired: the handshake completes and prio
            // rotates, but the write enable stays low.
            r_rf_write          <= |w_sel_reg;
            r_rf_write_register <= w_sel_reg;
            r_rf_write_data     <= w_sel_data;
            r_prio              <= alu_ready ? REQ_MEM : REQ_ALU;
        end else begin
            r_rf_write          <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard. The decrement is taken from the registered
    // write enable, so busy drops on the same edge the register file
    // captures the data.
    // ------------------------------------------------------------------
    assign busy[0]   = 1'b0;
    assign w_drop[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        logic w_inc;
        logic w_dec;
        logic w_sat;

        assign w_inc     = reserve_valid && (reserve_reg == ADDR_W'(i));
        assign w_dec     = r_rf_write && (r_rf_write_register == ADDR_W'(i));
        // A reserve coinciding with a commit nets to no change, so it is
        // never dropped even at saturation.
        assign w_drop[i] = w_inc & ~w_dec & w_sat;

        regfile_pending_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_inc  (w_inc),
            .i_dec  (w_dec),
            .o_busy (busy[i]),
            .o_sat  (w_sat)
        );
    end : g_cnt

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reserve_overflow <= 1'b0;
        end else begin
            r_reserve_overflow <= |w_drop;
        end
    end

    assign rf_write          = r_rf_write;
    assign rf_write_register = r_rf_write_register;
    assign rf_write_data     = r_rf_write_data;
    assign reserve_overflow  = r_reserve_overflow;

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A vector table
//               drives reserves and write-back requests with hand-derived
//               ready expectations; accepted writes are queued as expected
//               register-file outputs and compared one cycle later, and a
//               small count model predicts busy and reserve_overflow.
//               A hand-written sequence covers reset in mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                reserve_valid;
    logic [ADDR_W-1:0]   reserve_reg;
    logic                alu_valid;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_reg;
    logic [DATA_W-1:0]   alu_data;
    logic                mem_valid;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_reg;
    logic [DATA_W-1:0]   mem_data;
    logic                rf_write;
    logic [ADDR_W-1:0]   rf_write_register;
    logic [DATA_W-1:0]   rf_write_data;
    logic [NUM_REGS-1:0] busy;
    logic                reserve_overflow;

    always #5 clk = ~clk;

    regfile_wb_arbiter u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .reserve_valid     (reserve_valid),
        .reserve_reg       (reserve_reg),
        .alu_valid         (alu_valid),
        .alu_ready         (alu_ready),
        .alu_reg           (alu_reg),
        .alu_data          (alu_data),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_reg           (mem_reg),
        .mem_data          (mem_data),
        .rf_write          (rf_write),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .busy              (busy),
        .reserve_overflow  (reserve_overflow)
    );

    typedef struct {
        logic              rv;
        logic [ADDR_W-1:0] rreg;
        logic              av;
        logic [ADDR_W-1:0] areg;
        logic [DATA_W-1:0] adata;
        logic              mv;
        logic [ADDR_W-1:0] mreg;
        logic [DATA_W-1:0] mdata;
        logic              exp_ar;
        logic              exp_mr;
    } vec_t;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    localparam int NVEC = 26;

    vec_t vecs [NVEC];
    wb_t  sb [$];
    int   m_cnt [NUM_REGS];
    logic m_ovf;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rv, input int rreg,
                                input logic av, input int areg, input int adata,
                                input logic mv, input int mreg, input int mdata,
                                input logic ar, input logic mr);
        vec_t v;
        v.rv     = rv;
        v.rreg   = ADDR_W'(rreg);
        v.av     = av;
        v.areg   = ADDR_W'(areg);
        v.adata  = DATA_W'(adata);
        v.mv     = mv;
        v.mreg   = ADDR_W'(mreg);
        v.mdata  = DATA_W'(mdata);
        v.exp_ar = ar;
        v.exp_mr = mr;
        return v;
    endfunction

    function automatic logic [NUM_REGS-1:0] model_busy();
        logic [NUM_REGS-1:0] b;
        b = '0;
        for (int i = 1; i < NUM_REGS; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic drive_idle();
        reserve_valid = 1'b0; reserve_reg = '0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    endtask

    initial begin
        wb_t exp;
        wb_t nxt;
        logic new_ovf;
        int   r;

        //        rv rreg av areg adata    mv mreg mdata    ar mr
        vecs[0]  = mk(1, 4, 0, 0, 0,       0, 0, 0,       0, 0); // reserve r4
        vecs[1]  = mk(1, 4, 0, 0, 0,       0, 0, 0,       0, 0); // reserve r4 again
        vecs[2]  = mk(1, 3, 1, 3, 'h1111,  1, 5, 'h2222,  1, 0); // contention: ALU
        vecs[3]  = mk(0, 0, 1, 3, 'h1111,  1, 5, 'h2222,  0, 1); // MEM
        vecs[4]  = mk(0, 0, 1, 3, 'h1111,  1, 5, 'h2222,  1, 0); // ALU
        vecs[5]  = mk(0, 0, 1, 3, 'h1111,  1, 5, 'h2222,  0, 1); // MEM
        vecs[6]  = mk(0, 0, 1, 0, 'hBEEF,  0, 0, 0,       1, 0); // write to r0
        vecs[7]  = mk(0, 0, 1, 4, 'h4444,  1, 5, 'h5555,  0, 1); // prio moved to MEM
        vecs[8]  = mk(0, 0, 1, 4, 'h4445,  0, 0, 0,       1, 0); // commit r4 #1
        vecs[9]  = mk(0, 0, 1, 4, 'h4446,  0, 0, 0,       1, 0); // commit r4 #2 (lone)
        vecs[10] = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0);
        vecs[11] = mk(1, 2, 0, 0, 0,       0, 0, 0,       0, 0); // reserve r2
        vecs[12] = mk(0, 0, 1, 2, 'h2020,  0, 0, 0,       1, 0); // write r2
        vecs[13] = mk(1, 2, 0, 0, 0,       0, 0, 0,       0, 0); // reserve on commit edge
        vecs[14] = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0);
        vecs[15] = mk(1, 6, 0, 0, 0,       0, 0, 0,       0, 0); // r6 saturation
        vecs[16] = mk(1, 6, 0, 0, 0,       0, 0, 0,       0, 0);
        vecs[17] = mk(1, 6, 0, 0, 0,       0, 0, 0,       0, 0);
        vecs[18] = mk(1, 6, 0, 0, 0,       0, 0, 0,       0, 0); // dropped
        vecs[19] = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0);
        vecs[21] = mk(1, 0, 0, 0, 0,       0, 0, 0,       0, 0); // reserve r0 ignored
        vecs[22] = mk(0, 0, 0, 0, 0,       1, 7, 'h7777,  0, 1); // lone MEM
        vecs[23] = mk(0, 0, 1, 1, 'h0101,  1, 2, 'h0202,  1, 0);
        vecs[24] = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0);
        vecs[25] = mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0);

        for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
        m_ovf = 1'b0;

        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{wr: 1'b0, addr: '0, data: '0});

        for (int k = 0; k < NVEC; k++) begin
            // Outputs produced by the previous edge.
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty[%0d]: got empty queue, expected one entry", k);
                exp = '{wr: 1'b0, addr: '0, data: '0};
            end else begin
                exp = sb.pop_front();
            end
            check($sformatf("rf_write[%0d]", k), 32'(rf_write), 32'(exp.wr));
            check($sformatf("rf_addr[%0d]", k), 32'(rf_write_register), 32'(exp.addr));
            check($sformatf("rf_data[%0d]", k), 32'(rf_write_data), 32'(exp.data));
            check($sformatf("busy[%0d]", k), 32'(busy), 32'(model_busy()));
            check($sformatf("overflow[%0d]", k), 32'(reserve_overflow), 32'(m_ovf));

            reserve_valid = vecs[k].rv;
            reserve_reg   = vecs[k].rreg;
            alu_valid     = vecs[k].av;
            alu_reg       = vecs[k].areg;
            alu_data      = vecs[k].adata;
            mem_valid     = vecs[k].mv;
            mem_reg       = vecs[k].mreg;
            mem_data      = vecs[k].mdata;
            #1;
            check($sformatf("alu_ready[%0d]", k), 32'(alu_ready), 32'(vecs[k].exp_ar));
            check($sformatf("mem_ready[%0d]", k), 32'(mem_ready), 32'(vecs[k].exp_mr));

            // Expected register-file outputs after this edge.
            if (vecs[k].exp_ar)
                nxt = '{wr: (vecs[k].areg != 0), addr: vecs[k].areg, data: vecs[k].adata};
            else if (vecs[k].exp_mr)
                nxt = '{wr: (vecs[k].mreg != 0), addr: vecs[k].mreg, data: vecs[k].mdata};
            else
                nxt = '{wr: 1'b0, addr: exp.addr, data: exp.data};
            sb.push_back(nxt);

            // Pending counts after this edge: exp is what the file commits now.
            new_ovf = 1'b0;
            r = int'(vecs[k].rreg);
            if (vecs[k].rv && r != 0 && !(exp.wr && int'(exp.addr) == r)) begin
                if (m_cnt[r] == 3) new_ovf = 1'b1;
                else m_cnt[r]++;
            end
            if (exp.wr && !(vecs[k].rv && vecs[k].rreg == exp.addr)) begin
                if (m_cnt[int'(exp.addr)] != 0) m_cnt[int'(exp.addr)]--;
            end
            m_ovf = new_ovf;

            @(posedge clk);
            @(negedge clk);
        end

        // --------------------------------------------------------------
        // Reset in mid-operation: a write in flight plus an overflow pulse.
        // r6 is still saturated from the table.
        // --------------------------------------------------------------
        sb.delete();
        reserve_valid = 1'b1; reserve_reg = 3'd6;
        alu_valid = 1'b1; alu_reg = 3'd3; alu_data = 16'h3333;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_rf_write", 32'(rf_write), 32'd1);
        check("pre_rst_overflow", 32'(reserve_overflow), 32'd1);
        check("pre_rst_busy6", 32'(busy[6]), 32'd1);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rf_write", 32'(rf_write), 32'd0);
        check("rst_rf_addr", 32'(rf_write_register), 32'd0);
        check("rst_rf_data", 32'(rf_write_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(reserve_overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Before reset the last grant went to ALU, so only a prio reset
        // lets ALU win this contention.
        alu_valid = 1'b1; alu_reg = 3'd1; alu_data = 16'hA1A1;
        mem_valid = 1'b1; mem_reg = 3'd2; mem_data = 16'hB2B2;
        #1;
        check("post_rst_alu_ready", 32'(alu_ready), 32'd1);
        check("post_rst_mem_ready", 32'(mem_ready), 32'd0);
        @(posedge clk);
        #1;
        drive_idle();
        check("post_rst_rf_write", 32'(rf_write), 32'd1);
        check("post_rst_rf_addr", 32'(rf_write_register), 32'd1);
        check("post_rst_rf_data", 32'(rf_write_data), 32'hA1A1);
        @(posedge clk);
        #1;
        check("post_rst_idle_write", 32'(rf_write), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
